// File: rtl/sign_mag_pkg.sv
// Shared types and constants for the sign/magnitude to bipolar recombiner.
// The LFSR constants are used only when SIGN_MAG_LFSR_EN is defined.
package sign_mag_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int                LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/half_stream_gen.sv
// Source of the probability-1/2 bit used wherever mag is 0.
// Deterministic toggle by default; 8-bit LFSR when SIGN_MAG_LFSR_EN is defined.
module half_stream_gen
    import sign_mag_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic adv,
    output logic half
);

`ifdef SIGN_MAG_LFSR_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (init) begin
            lfsr <= LFSR_SEED;
        end else if (adv) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb(lfsr)};
        end
    end

    assign half = lfsr[0];
`else
    logic toggle;

    // Seed 0 makes the first non-mag bit of every frame a 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle <= 1'b0;
        end else if (init) begin
            toggle <= 1'b0;
        end else if (adv) begin
            toggle <= ~toggle;
        end
    end

    assign half = toggle;
`endif

endmodule

// File: rtl/sign_mag_bipolar.sv
// Recombines a sign bit and a unary magnitude stream into a bipolar stream over
// a 2^CW-bit frame. Build option: SIGN_MAG_LFSR_EN selects an LFSR half source.
module sign_mag_bipolar
    import sign_mag_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic sign_in,
    input  logic en,
    input  logic mag,
    output logic out,
    output logic out_vld,
    output logic busy,
    output logic done
);

    // Handshake: no back-pressure. Each cycle with en=1 in RUN accepts one mag
    // bit; exactly one cycle later out_vld=1 presents its bipolar bit on out.
    state_e        state;
    state_e        state_next;
    logic [CW-1:0] cnt;
    logic          sgn;
    logic          half;
    logic          accept_start;
    logic          accept_bit;
    logic          last_bit;

    assign accept_start = (state == IDLE) && start;
    assign accept_bit   = (state == RUN) && en;
    assign last_bit     = accept_bit && (cnt == {CW{1'b1}});

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sgn     <= 1'b0;
            out     <= 1'b0;
            out_vld <= 1'b0;
            done    <= 1'b0;
        end else begin
            out_vld <= accept_bit;
            done    <= last_bit;
            if (accept_start) begin
                sgn <= sign_in;
                cnt <= '0;
            end
            // cnt wraps to 0 on the last bit of the frame.
            if (accept_bit) begin
                out <= mag ? ~sgn : half;
                cnt <= cnt + 1'b1;
            end
        end
    end

    half_stream_gen u_half (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (accept_start),
        .adv   (accept_bit && !mag),
        .half  (half)
    );

    assign busy = (state == RUN);

endmodule

// File: tb/tb_sign_mag_bipolar.sv
// Self-checking bench for sign_mag_bipolar with CW=4 (16-bit frames).
module tb_sign_mag_bipolar;

    localparam int CW = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sign_in;
    logic en;
    logic mag;
    logic out;
    logic out_vld;
    logic busy;
    logic done;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [0:0] exp_q[$];
    logic last_out;

    sign_mag_bipolar #(.CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sign_in (sign_in),
        .en      (en),
        .mag     (mag),
        .out     (out),
        .out_vld (out_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // A cycle in IDLE with en high must produce nothing.
    task automatic idle_check();
        @(negedge clk);
        start   = 1'b0;
        en      = 1'b1;
        mag     = 1'b1;
        sign_in = 1'($urandom);
        @(posedge clk);
        #1;
        check("idle_vld", 8'(out_vld), 8'd0);
        check("idle_done", 8'(done), 8'd0);
        check("idle_busy", 8'(busy), 8'd0);
        check("idle_out_hold", 8'(out), 8'(last_out));
        en = 1'b0;
    endtask

    // en_mode: 0 always en, 1 alternate, 2 random gaps.
    task automatic run_frame(input logic sgn, input logic [N-1:0] pat, input int en_mode,
                             input bit mid_start, input int reset_at);
        int   acc;
        int   cyc;
        int   ones;
        int   m;
        int   z;
        logic e;
        logic ex;
        acc  = 0;
        cyc  = 0;
        ones = 0;
        exp_q.delete();
        // Reference: mag bit gives ~sign; the k-th non-mag bit (k from 0) gives k%2.
        for (int i = 0; i < N; i++) begin
            z = 0;
            for (int j = 0; j < i; j++) if (!pat[j]) z++;
            exp_q.push_back(pat[i] ? ~sgn : ((z % 2) != 0));
        end

        @(negedge clk);
        start   = 1'b1;
        sign_in = sgn;
        en      = 1'b0;
        mag     = 1'b0;
        @(posedge clk);
        #1;
        check("busy_rise", 8'(busy), 8'd1);
        check("vld_at_start", 8'(out_vld), 8'd0);

        while (acc < N && cyc < 200) begin
            @(negedge clk);
            if (en_mode == 0)      e = 1'b1;
            else if (en_mode == 1) e = (cyc % 2) == 0;
            else                   e = ($urandom_range(0, 3) != 0);
            en      = e;
            mag     = pat[acc];
            start   = mid_start && (acc == 5 || acc == N - 1);
            sign_in = ~sgn;
            if (reset_at >= 0 && acc == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_out", 8'(out), 8'd0);
                check("rst_vld", 8'(out_vld), 8'd0);
                check("rst_busy", 8'(busy), 8'd0);
                check("rst_done", 8'(done), 8'd0);
                #1 rst_n = 1'b1;
                start = 1'b0;
                en    = 1'b1;
                @(posedge clk);
                #1;
                check("post_rst_vld", 8'(out_vld), 8'd0);
                check("post_rst_busy", 8'(busy), 8'd0);
                check("post_rst_done", 8'(done), 8'd0);
                check("post_rst_out", 8'(out), 8'd0);
                last_out = 1'b0;
                en       = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (e) begin
                ex = exp_q.pop_front();
                check("out_bit", 8'(out), 8'(ex));
                check("vld_on", 8'(out_vld), 8'd1);
                check("done_flag", 8'(done), (acc == N - 1) ? 8'd1 : 8'd0);
                ones     = ones + int'(out);
                last_out = ex;
                acc++;
            end else begin
                check("vld_gap", 8'(out_vld), 8'd0);
                check("done_gap", 8'(done), 8'd0);
                check("out_hold", 8'(out), 8'(last_out));
            end
            check("busy_run", 8'(busy), (acc < N) ? 8'd1 : 8'd0);
            cyc++;
        end
        if (acc < N) check("frame_timeout", 8'(acc), 8'(N));
        m = $countones(pat);
        check("ones_count", 8'(ones), sgn ? 8'((N - m) / 2) : 8'(m + (N - m) / 2));
        start = 1'b0;
        en    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        sign_in  = 1'b0;
        en       = 1'b0;
        mag      = 1'b0;
        last_out = 1'b0;
        #12;
        check("reset_out", 8'(out), 8'd0);
        check("reset_vld", 8'(out_vld), 8'd0);
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_done", 8'(done), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check();

        run_frame(1'b0, 16'hFFFF, 0, 1'b0, -1);
        idle_check();
        run_frame(1'b1, 16'hFFFF, 0, 1'b0, -1);
        run_frame(1'b0, 16'h0000, 0, 1'b0, -1);
        run_frame(1'b0, 16'h000F, 0, 1'b0, -1);
        run_frame(1'b1, 16'h000F, 0, 1'b0, -1);
        run_frame(1'b0, 16'h3C5A, 1, 1'b1, -1);
        idle_check();
        run_frame(1'b1, 16'h0F0F, 1, 1'b1, -1);
        run_frame(1'b0, 16'($urandom), 0, 1'b0, 7);
        run_frame(1'b0, 16'h000F, 0, 1'b0, -1);
        run_frame(1'b1, 16'h000F, 0, 1'b0, -1);
        for (int f = 0; f < 8; f++) begin
            run_frame(1'($urandom), 16'($urandom), 2, 1'($urandom_range(0, 1)), -1);
        end
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
